acl2_tilt_filter: RTL
=====================

ACL2_TILT_FILTER -- requirements
Module: acl2_tilt_filter

Interface
- REQ-001 Parameter AVG_LOG2, default 2: log2 of moving-average window depth (DEPTH = 2^AVG_LOG2, legal 1..4).
- REQ-002 Parameter THRESH, default 256: tilt entry threshold, signed 12-bit magnitude, in raw sample units.
- REQ-003 Parameter HYST, default 64: hysteresis margin, used only with ACL2_TILT_HYST_EN; HYST < THRESH.
- REQ-004 clk  input  1  single system clock; all state updates on rising edge.
- REQ-005 rst  input  1  synchronous active-low reset, sampled on clk rising edge.
- REQ-006 sample_valid  input  1  one-cycle strobe: sample/axis_sel valid this cycle.
- REQ-007 axis_sel  input  2  0=X, 1=Y, 2=Z, 3=reserved.
- REQ-008 sample  input  12  signed two's-complement acceleration from the ACL2 controller dout.
- REQ-009 avg_x, avg_y, avg_z  output  12 each  signed windowed averages.
- REQ-010 primed  output  1  high once every axis window has received DEPTH samples.
- REQ-011 tilt  output  3  0=FLAT, 1=LEFT, 2=RIGHT, 3=FWD, 4=BACK; 5..7 never driven.
- REQ-012 out_valid  output  1  one-cycle pulse when tilt re-evaluated.
- REQ-013 tilt_changed  output  1  one-cycle pulse, coincident with out_valid, when tilt differs from previous value.

Function
- REQ-014 Sample accepted when sample_valid=1 and axis_sel<=2 on a clk edge with rst=1; axis_sel=3 ignored, no state change.
- REQ-015 Per axis: DEPTH-entry circular buffer, write pointer wraps modulo DEPTH, running sum of width 12+AVG_LOG2 signed.
- REQ-016 On acceptance: sum <= sum + sample - oldest entry; oldest entry overwritten; pointer advances.
- REQ-017 avg_<axis> = sum arithmetically shifted right by AVG_LOG2 (floor toward -inf); registered, valid one cycle after acceptance.
- REQ-018 Empty buffer entries are zero, so averages ramp during fill; no saturation needed (sum width exact).
- REQ-019 Per-axis fill counter saturates at DEPTH; primed = all three counters at DEPTH, updated with the averages.
- REQ-020 Evaluation tick: Z sample accepted at cycle T with primed true at T+1 -> tilt, out_valid, tilt_changed registered at T+2; no tick otherwise.
- REQ-021 Base classification (priority order): avg_x > THRESH -> RIGHT; avg_x < -THRESH -> LEFT; avg_y > THRESH -> FWD; avg_y < -THRESH -> BACK; else FLAT.
- REQ-022 Tilt FSM states FLAT/LEFT/RIGHT/FWD/BACK; transitions only on evaluation tick; between ticks tilt holds.
- REQ-023 Comparisons are strict, signed, 12-bit; avg equal to +/-THRESH does not tilt.
- REQ-024 Back-to-back samples every cycle sustained; a new Z while a tick is pending uses the newest averages on its own tick.

Reset
- REQ-025 rst=0 at clk edge: buffers, sums, pointers, fill counters cleared; avg_x/y/z=0; primed=0; tilt=FLAT; out_valid=0; tilt_changed=0.
- REQ-026 Reset mid-fill or mid-tick discards partial windows and any pending tick; sample_valid ignored while rst=0.

Configuration
- REQ-027 Macro ACL2_TILT_HYST_EN defined: in tilt state S, stay in S while S's axis remains beyond THRESH-HYST in S's direction; otherwise apply REQ-021.
- REQ-028 Macro undefined: every tick applies REQ-021 directly; HYST unused; no hysteresis logic synthesized.

Verification (AVG_LOG2=2, THRESH=256, HYST=64)
- REQ-029 Reset, 4 rounds X=100,Y=-200,Z=256 -> avg 100/-200/256, primed after 4th Z, out_valid at T+2, tilt=FLAT, tilt_changed=0.
- REQ-030 Wrap: X=400 x4 from reset -> avg_x 100,200,300,400; next X=0 -> 300.
- REQ-031 Floor: X samples -1,0,0,0 -> avg_x=-1 after each; X=-4,0,0,0 -> -1 after first.
- REQ-032 Hysteresis: steady avg_x=300 -> RIGHT with tilt_changed pulse; avg_x=220 -> RIGHT (macro) / FLAT (no macro); avg_x=180 -> FLAT both.
- REQ-033 axis_sel=3 with sample=2047 -> no avg change; rst low after 2 rounds -> all outputs zero/FLAT, next primed needs 4 full rounds.

Source files
------------

// File: rtl/acl2_tilt_filter.sv
// ACL2 accelerometer moving-average filter with tilt classifier.
// Define ACL2_TILT_HYST_EN to hold a tilt until its axis falls inside THRESH-HYST.
module acl2_tilt_filter #(
    parameter int AVG_LOG2 = 2,
    parameter int THRESH   = 256,
    parameter int HYST     = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_valid,
    input  logic [1:0]         axis_sel,
    input  logic signed [11:0] sample,
    output logic signed [11:0] avg_x,
    output logic signed [11:0] avg_y,
    output logic signed [11:0] avg_z,
    output logic               primed,
    output logic [2:0]         tilt,
    output logic               out_valid,
    output logic               tilt_changed
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = 12 + AVG_LOG2;

    localparam logic [AVG_LOG2:0]   FULL  = (AVG_LOG2 + 1)'(DEPTH);
    localparam logic [AVG_LOG2:0]   FONE  = (AVG_LOG2 + 1)'(1);
    localparam logic [AVG_LOG2-1:0] PONE  = AVG_LOG2'(1);
    localparam logic signed [11:0]  TH    = 12'(THRESH);

    if (HYST >= THRESH || AVG_LOG2 < 1 || AVG_LOG2 > 4) begin : g_bad_param
        $error("acl2_tilt_filter: illegal parameter set");
    end

    typedef enum logic [2:0] {
        FLAT  = 3'd0,
        LEFT  = 3'd1,
        RIGHT = 3'd2,
        FWD   = 3'd3,
        BACK  = 3'd4
    } tilt_t;

    logic signed [11:0]   ring [0:2][DEPTH];
    logic signed [SW-1:0] sum  [0:2];
    logic signed [11:0]   avg  [0:2];
    logic [AVG_LOG2-1:0]  wptr [0:2];
    logic [AVG_LOG2:0]    fill [0:2];

    logic                 z_pend;
    tilt_t                state;
    tilt_t                nxt_tilt;

    logic [1:0]           sel;
    logic                 accept;
    logic signed [SW-1:0] sum_nxt;
    logic [AVG_LOG2:0]    fill_nxt;
    logic                 primed_nxt;

    function automatic tilt_t classify(input logic signed [11:0] ax,
                                       input logic signed [11:0] ay);
        tilt_t r;
        priority case (1'b1)
            (ax > TH):  r = RIGHT;
            (ax < -TH): r = LEFT;
            (ay > TH):  r = FWD;
            (ay < -TH): r = BACK;
            default:    r = FLAT;
        endcase
        return r;
    endfunction

    always_comb begin
        sel        = (axis_sel == 2'd3) ? 2'd0 : axis_sel;
        accept     = sample_valid && (axis_sel != 2'd3);
        sum_nxt    = sum[sel] + SW'(sample) - SW'(ring[sel][wptr[sel]]);
        fill_nxt   = (fill[sel] == FULL) ? fill[sel] : fill[sel] + FONE;
        primed_nxt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (((2'(i) == sel) ? fill_nxt : fill[i]) != FULL)
                primed_nxt = 1'b0;
        end
    end

`ifdef ACL2_TILT_HYST_EN
    localparam logic signed [11:0] HOLD = 12'(THRESH - HYST);

    // An active tilt survives while its own axis stays past the lowered bar.
    always_comb begin
        nxt_tilt = classify(avg[0], avg[1]);
        unique case (state)
            RIGHT:   if (avg[0] > HOLD)  nxt_tilt = RIGHT;
            LEFT:    if (avg[0] < -HOLD) nxt_tilt = LEFT;
            FWD:     if (avg[1] > HOLD)  nxt_tilt = FWD;
            BACK:    if (avg[1] < -HOLD) nxt_tilt = BACK;
            default: ;
        endcase
    end
`else
    always_comb begin
        nxt_tilt = classify(avg[0], avg[1]);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int a = 0; a < 3; a++) begin
                for (int d = 0; d < DEPTH; d++) ring[a][d] <= '0;
                sum[a]  <= '0;
                avg[a]  <= '0;
                wptr[a] <= '0;
                fill[a] <= '0;
            end
            primed       <= 1'b0;
            z_pend       <= 1'b0;
            state        <= FLAT;
            out_valid    <= 1'b0;
            tilt_changed <= 1'b0;
        end else begin
            z_pend       <= accept && (axis_sel == 2'd2);
            out_valid    <= 1'b0;
            tilt_changed <= 1'b0;
            if (accept) begin
                ring[sel][wptr[sel]] <= sample;
                sum[sel]  <= sum_nxt;
                avg[sel]  <= 12'(sum_nxt >>> AVG_LOG2);
                wptr[sel] <= wptr[sel] + PONE;
                fill[sel] <= fill_nxt;
                primed    <= primed_nxt;
            end
            // Tick uses averages as they stand one cycle after the Z sample.
            if (z_pend && primed) begin
                state        <= nxt_tilt;
                out_valid    <= 1'b1;
                tilt_changed <= (nxt_tilt != state);
            end
        end
    end

    assign avg_x = avg[0];
    assign avg_y = avg[1];
    assign avg_z = avg[2];
    assign tilt  = state;

endmodule
